// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, press-edge detect.
// o_level is the debounced pressed state; o_press pulses on each accepted press.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;
  logic          differ;
  logic          expire;

  assign differ = (sync_q[1] != level_q);
  assign expire = (cnt_q == CW'(DB_CYCLES - 1));

  // level_q tracks the active-low pin: 1 = released
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_btn_n};
      press_q <= level_q && differ && expire;
      if (!differ) begin
        cnt_q <= '0;
      end else if (expire) begin
        cnt_q   <= '0;
        level_q <= ~level_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign o_level = ~level_q;
  assign o_press = press_q;

endmodule

// File: rtl/roll_ctrl.sv
// Dice-roll sequencer: a debounced press steps the LFSR NUM_STEPS times
// at a decelerating rate, latching each new value for the display.
module roll_ctrl #(
  parameter int unsigned W_DATA     = 16,
  parameter int unsigned DB_CYCLES  = 500_000,
  parameter int unsigned STEP_START = 1_000_000,
  parameter int unsigned STEP_INC   = 500_000,
  parameter int unsigned NUM_STEPS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_btn_n,
  input  logic [W_DATA-1:0] i_lfsr,
  output logic              o_lfsr_en,
  output logic [W_DATA-1:0] o_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned PW =
    $clog2(STEP_START + NUM_STEPS * STEP_INC + 1);
  localparam int unsigned SW = $clog2(NUM_STEPS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    ROLL = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     timer_q, timer_d;
  logic [PW-1:0]     period_q, period_d;
  logic [SW-1:0]     step_q, step_d;
  logic [W_DATA-1:0] data_q, data_d;
  logic              cap_q;
  logic              press;
  logic              level;
  logic              last;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db (
    .clk     (clk),
    .rst     (rst),
    .i_btn_n (i_btn_n),
    .o_level (level),
    .o_press (press)
  );

  assign last = (step_q == SW'(NUM_STEPS));

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    period_d  = period_q;
    step_d    = step_q;
    data_d    = data_q;
    o_lfsr_en = 1'b0;
    o_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press && level) begin
          state_d  = ROLL;
          timer_d  = '0;
          period_d = PW'(STEP_START);
          step_d   = '0;
        end
      end
      ROLL: begin
        // once all steps are issued, wait only for the final capture
        if (!last && timer_q == period_q - PW'(1)) begin
          o_lfsr_en = 1'b1;
          timer_d   = '0;
          period_d  = period_q + PW'(STEP_INC);
          step_d    = step_q + SW'(1);
        end else begin
          timer_d = timer_q + PW'(1);
        end
        if (cap_q && last) begin
          o_done  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (cap_q) begin
      data_d = i_lfsr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      period_q <= '0;
      step_q   <= '0;
      data_q   <= '0;
      cap_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      period_q <= period_d;
      step_q   <= step_d;
      data_q   <= data_d;
      cap_q    <= o_lfsr_en;
    end
  end

  assign o_data = data_q;
  assign o_busy = (state_q == ROLL);

endmodule

// File: tb/tb_roll_ctrl.sv
// Bench for roll_ctrl: event-schedule reference model, directed
// scenarios and randomized press/bounce/reset sequences.
module tb_roll_ctrl;

  localparam int W  = 16;
  localparam int DB = 4;
  localparam int S  = 3;
  localparam int I  = 2;
  localparam int N  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         btn_n = 1'b1;
  logic [W-1:0] lfsr = 16'hACE1;
  logic         en;
  logic         busy;
  logic         done;
  logic [W-1:0] data;

  always #5 clk = ~clk;

  roll_ctrl #(
    .W_DATA     (W),
    .DB_CYCLES  (DB),
    .STEP_START (S),
    .STEP_INC   (I),
    .NUM_STEPS  (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_btn_n   (btn_n),
    .i_lfsr    (lfsr),
    .o_lfsr_en (en),
    .o_data    (data),
    .o_busy    (busy),
    .o_done    (done)
  );

  // stand-in for the board LFSR
  always @(posedge clk)
    if (en) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit s0 = 1, s1 = 1, lvl = 1;
  int run = 0;
  bit active = 0;
  int t0 = 0;
  int st [1:N];
  int done_cyc = 0;
  bit last_cap = 0;
  logic [W-1:0] exp_data = '0;
  logic [W-1:0] prev_lfsr = '0;
  logic [W-1:0] prev_data = '0;
  logic prev_busy = 1'b0;
  int roll_strobes = 0;
  int dut_done_total = 0;
  int model_done_total = 0;

  int press_log[$];
  int strobe_log[$];
  int done_log[$];
  int rise_log[$];
  logic [W-1:0] data_log[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit is_strobe(input int c);
    if (!active) return 1'b0;
    for (int k = 1; k <= N; k++)
      if (st[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_update(input logic b, input logic r);
    bit press;
    last_cap = 0;
    if (r) begin
      s0 = 1; s1 = 1; lvl = 1; run = 0;
      active = 0; exp_data = '0; roll_strobes = 0;
    end else begin
      if (is_strobe(cyc - 2)) begin
        exp_data = prev_lfsr;
        last_cap = 1;
      end
      press = 0;
      if (s1 != lvl) begin
        run++;
        if (run == DB) begin
          lvl = s1;
          run = 0;
          press = (lvl == 0);
        end
      end else begin
        run = 0;
      end
      s1 = s0;
      s0 = b;
      if (press && !(active && cyc > t0 && cyc <= done_cyc)) begin
        active = 1;
        t0 = cyc;
        st[1] = cyc + S;
        for (int k = 2; k <= N; k++) st[k] = st[k-1] + S + (k - 1) * I;
        done_cyc = st[N] + 1;
        roll_strobes = 0;
        press_log.push_back(cyc);
      end
    end
  endtask

  task automatic compare(input logic r);
    logic e_en, e_done, e_busy;
    e_en   = is_strobe(cyc);
    e_done = active && cyc == done_cyc;
    e_busy = active && cyc > t0 && cyc <= done_cyc;
    chk("lfsr_en", en, e_en);
    chk("done", done, e_done);
    chk("busy", busy, e_busy);
    chk("data", data, exp_data);
    chk("data_hold", (data === prev_data) || last_cap || r, 1);
    if (en === 1'b1) begin
      roll_strobes++;
      strobe_log.push_back(cyc);
    end
    if (done === 1'b1) begin
      dut_done_total++;
      done_log.push_back(cyc);
    end
    if (e_done) begin
      model_done_total++;
      chk("strobes_per_roll", roll_strobes, N);
    end
    if (data !== prev_data) data_log.push_back(data);
    if (busy === 1'b1 && prev_busy !== 1'b1) rise_log.push_back(cyc);
    prev_data = data;
    prev_busy = busy;
    prev_lfsr = lfsr;
  endtask

  task automatic step(input logic b, input logic r);
    btn_n = b;
    rst = r;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    model_update(b, r);
    compare(r);
  endtask

  task automatic clear_logs();
    press_log.delete();
    strobe_log.delete();
    done_log.delete();
    rise_log.delete();
    data_log.delete();
  endtask

  task automatic check_offsets(input string nm, input int t);
    int off [4];
    off = '{3, 8, 15, 24};
    chk({nm, "_strobes"}, strobe_log.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < strobe_log.size())
        chk({nm, "_off"}, strobe_log[k] - t, off[k]);
    chk({nm, "_dones"}, done_log.size(), 1);
    if (done_log.size() > 0) chk({nm, "_done_off"}, done_log[0] - t, 25);
    chk({nm, "_rises"}, rise_log.size(), 1);
    if (rise_log.size() > 0) chk({nm, "_rise_off"}, rise_log[0] - t, 1);
  endtask

  initial begin
    int t, n, cl, cl2, nseg;

    repeat (3) step(1, 1);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", en, 0);
    chk("rst_done", done, 0);

    // bounces that never stay low long enough
    clear_logs();
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(1, 3)) step(0, 0);
      repeat ($urandom_range(1, 3)) step(1, 0);
    end
    repeat (8) step(1, 0);
    chk("t1_rolls", rise_log.size(), 0);
    chk("t1_strobes", strobe_log.size(), 0);

    // clean press
    clear_logs();
    repeat (40) step(0, 0);
    repeat (15) step(1, 0);
    chk("t2_press", press_log.size(), 1);
    t = (press_log.size() > 0) ? press_log[0] : 0;
    check_offsets("t2", t);
    chk("t2_model_done", done_cyc - t0, 25);
    chk("t2_first_data", (data_log.size() > 0) ? data_log[0] : 0, 16'h59C3);

    // second press during the roll is ignored
    clear_logs();
    n = 0;
    while (press_log.size() == 0 && n < 30) begin
      step(0, 0);
      n++;
    end
    t = (press_log.size() > 0) ? press_log[0] : 0;
    repeat (5) step(1, 0);
    repeat (30) step(0, 0);
    repeat (15) step(1, 0);
    check_offsets("t3", t);

    // reset mid-roll
    clear_logs();
    n = 0;
    while (press_log.size() == 0 && n < 30) begin
      step(0, 0);
      n++;
    end
    t = (press_log.size() > 0) ? press_log[0] : 0;
    while (cyc < t + 12) step(1, 0);
    step(1, 1);
    chk("t4_busy", busy, 0);
    chk("t4_data", data, 0);
    chk("t4_done", done, 0);
    strobe_log.delete();
    repeat (30) step(1, 0);
    chk("t4_no_en", strobe_log.size(), 0);

    // held through roll end, then a fresh press
    clear_logs();
    cl = cyc + 1;
    repeat (50) step(0, 0);
    repeat (10) step(1, 0);
    cl2 = cyc + 1;
    repeat (40) step(0, 0);
    repeat (15) step(1, 0);
    chk("t5_rises", rise_log.size(), 2);
    if (rise_log.size() == 2) begin
      chk("t5_lat1", rise_log[0] - cl, 6);
      chk("t5_lat2", rise_log[1] - cl2, 6);
    end
    chk("t5_dones", done_log.size(), 2);
    chk("t5_strobes", strobe_log.size(), 2 * N);

    // randomized sequences
    for (int s = 0; s < 20; s++) begin
      nseg = $urandom_range(3, 6);
      for (int g = 0; g < nseg; g++) begin
        case ($urandom_range(0, 5))
          0: repeat ($urandom_range(2, 8)) begin
               repeat ($urandom_range(1, 3)) step(0, 0);
               repeat ($urandom_range(1, 3)) step(1, 0);
             end
          1, 2: begin
               repeat ($urandom_range(5, 45)) step(0, 0);
               repeat ($urandom_range(5, 20)) step(1, 0);
             end
          3, 4: repeat ($urandom_range(1, 30)) step(1, 0);
          default: step(btn_n, 1);
        endcase
      end
      repeat (40) step(1, 0);
    end

    chk("done_total", dut_done_total, model_done_total);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
